// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch, load/store) arbiter onto one single-port RAM
// Optional: define MEM_ARBITER_RR_EN for round-robin tie-breaking instead of LS-over-IF priority.
module mem_arbiter #(
  parameter int AW          = 6,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [31:0]   ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          owner_ls_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic          if_rvalid_q;
  logic          ls_rvalid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] ls_rdata_q;

  logic arb_en;
  logic pick_ls;
  logic gnt_ls;
  logic gnt_if;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:AW+2], if_addr_i[1:0],
                              ls_addr_i[31:AW+2], ls_addr_i[1:0]};

  // Grants are only possible when no transaction is in flight; held low in reset.
  assign arb_en = ((state_q == IDLE) || (state_q == RESP)) && !rst_i;

`ifdef MEM_ARBITER_RR_EN
  logic last_if_q;
  assign pick_ls = ls_req_i && (!if_req_i || last_if_q);
`else
  assign pick_ls = ls_req_i;
`endif

  assign gnt_ls = arb_en && pick_ls;
  assign gnt_if = arb_en && if_req_i && !pick_ls;
  assign cnt_d  = cnt_q - CW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_ls_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_if_q   <= 1'b0;
`endif
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (gnt_ls || gnt_if) begin
            owner_ls_q <= gnt_ls;
            we_q       <= gnt_ls && ls_we_i;
            addr_q     <= gnt_ls ? ls_addr_i[AW+1:2] : if_addr_i[AW+1:2];
            wdata_q    <= gnt_ls ? ls_wdata_i : '0;
            mem_en_q   <= 1'b1;
            mem_we_q   <= gnt_ls && ls_we_i;
            state_q    <= ISSUE;
`ifdef MEM_ARBITER_RR_EN
            last_if_q  <= gnt_if;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          cnt_q   <= CW'(MEM_LATENCY);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          // Last wait cycle: mem_rdata is valid now, MEM_LATENCY cycles after mem_en.
          if (cnt_q == CW'(1)) begin
            state_q <= RESP;
            if (owner_ls_q) begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= we_q ? '0 : mem_rdata_i;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt_o    = gnt_if;
  assign ls_gnt_o    = gnt_ls;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (latency 1 and latency 3 instances)
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0]   if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;

  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3, mem_we3;
  logic [DW-1:0] if_rdata3, ls_rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0] mem_addr3;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  logic [DW-1:0] ram  [64];
  logic [DW-1:0] ram3 [64];
  logic [DW-1:0] p3_0, p3_1;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt3),
    .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt3), .ls_rvalid_o(ls_rvalid3), .ls_rdata_o(ls_rdata3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
    .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
  );

  // Latency-1 RAM: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  // Latency-3 RAM: read data appears three cycles after mem_en.
  always @(posedge clk) begin
    if (pre_we) ram3[pre_addr] <= pre_data;
    else if (mem_en3 && mem_we3) ram3[mem_addr3] <= mem_wdata3;
    p3_0       <= ram3[mem_addr3];
    p3_1       <= p3_0;
    mem_rdata3 <= p3_1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero output (mem_en=%b mem_addr=%h rdata=%h/%h)", mem_en, mem_addr, if_rdata, ls_rdata); end
    checks++; if ({if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3, mem_we3} !== '0) begin
      errors++; $display("FAIL reset_outputs3: got nonzero control output"); end
    step(); pre_we = 1'b1; pre_addr = 6'd5; pre_data = 32'hDEADBEEF;
    step(); pre_addr = 6'd1; pre_data = 32'hCAFEF00D;
    step(); pre_we = 1'b0;
    step(); rst = 1'b0;
    #1;
    checks++; if ({if_gnt, ls_gnt, mem_en} !== 3'b000) begin
      errors++; $display("FAIL reset_release_idle: got gnt/en=%b exp 000", {if_gnt, ls_gnt, mem_en}); end
  endtask

  task automatic test_single_load();
    step(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h14; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL load_ls_gnt: got %b exp 1", ls_gnt); end
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL load_if_gnt: got %b exp 0", if_gnt); end
    for (int c = 1; c <= 4; c++) begin
      step(); if (c == 1) ls_req = 1'b0; #1;
      checks++; if (mem_en !== (c == 1)) begin errors++; $display("FAIL load_mem_en c%0d: got %b", c, mem_en); end
      checks++; if (ls_rvalid !== (c == 3)) begin errors++; $display("FAIL load_ls_rvalid c%0d: got %b", c, ls_rvalid); end
      checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL load_if_rvalid c%0d: got %b exp 0", c, if_rvalid); end
      if (c == 1) begin
        checks++; if (mem_addr !== 6'd5) begin errors++; $display("FAIL load_mem_addr: got %0d exp 5", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_mem_we: got %b exp 0", mem_we); end
      end
      if (c >= 3) begin
        checks++; if (ls_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata c%0d: got %h exp deadbeef", c, ls_rdata); end
      end
    end
  endtask

  task automatic test_store_fetch();
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h08; ls_wdata = 32'h12345678; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b exp 1", ls_gnt); end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin ls_req = 1'b0; ls_we = 1'b0; end
      if (c == 3) begin if_req = 1'b1; if_addr = 32'h08; end
      if (c == 4) if_req = 1'b0;
      #1;
      checks++; if (mem_we !== (c == 1)) begin errors++; $display("FAIL store_mem_we c%0d: got %b", c, mem_we); end
      checks++; if (mem_en !== (c == 1 || c == 4)) begin errors++; $display("FAIL store_mem_en c%0d: got %b", c, mem_en); end
      checks++; if (ls_rvalid !== (c == 3)) begin errors++; $display("FAIL store_ls_rvalid c%0d: got %b", c, ls_rvalid); end
      checks++; if (if_rvalid !== (c == 6)) begin errors++; $display("FAIL fetch_if_rvalid c%0d: got %b", c, if_rvalid); end
      if (c == 1) begin
        checks++; if (mem_addr !== 6'd2) begin errors++; $display("FAIL store_mem_addr: got %0d exp 2", mem_addr); end
        checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL store_mem_wdata: got %h exp 12345678", mem_wdata); end
      end
      if (c == 3) begin
        checks++; if (ram[2] !== 32'h12345678) begin errors++; $display("FAIL store_committed: got %h exp 12345678", ram[2]); end
        checks++; if (ls_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_zero: got %h exp 0", ls_rdata); end
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt_in_resp: got %b exp 1", if_gnt); end
      end
      if (c == 6) begin
        checks++; if (if_rdata !== 32'h12345678) begin errors++; $display("FAIL fetch_rdata: got %h exp 12345678", if_rdata); end
      end
    end
  endtask

  task automatic test_simultaneous();
    bit exp_ls_win, prev_ls, tie, rv;
    int g;
    step(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h14; if_req = 1'b1; if_addr = 32'h08;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      if (c == 12) begin ls_req = 1'b0; if_req = 1'b0; end
      #1;
      g   = c / 3;
      tie = (c % 3 == 0) && (c < 12);
      rv  = (c % 3 == 0) && (c > 0);
`ifdef MEM_ARBITER_RR_EN
      exp_ls_win = (g % 2 == 0);
      prev_ls    = ((g - 1) % 2 == 0);
`else
      exp_ls_win = 1'b1;
      prev_ls    = 1'b1;
`endif
      checks++; if (ls_gnt !== (tie && exp_ls_win)) begin errors++; $display("FAIL sim_ls_gnt c%0d: got %b", c, ls_gnt); end
      checks++; if (if_gnt !== (tie && !exp_ls_win)) begin errors++; $display("FAIL sim_if_gnt c%0d: got %b", c, if_gnt); end
      checks++; if (ls_rvalid !== (rv && prev_ls)) begin errors++; $display("FAIL sim_ls_rvalid c%0d: got %b", c, ls_rvalid); end
      checks++; if (if_rvalid !== (rv && !prev_ls)) begin errors++; $display("FAIL sim_if_rvalid c%0d: got %b", c, if_rvalid); end
      if (rv && prev_ls) begin
        checks++; if (ls_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_ls_rdata c%0d: got %h exp deadbeef", c, ls_rdata); end
      end
      if (rv && !prev_ls) begin
        checks++; if (if_rdata !== 32'h12345678) begin errors++; $display("FAIL sim_if_rdata c%0d: got %h exp 12345678", c, if_rdata); end
      end
    end
  endtask

  task automatic test_latency3_wrap();
    repeat (8) step();
    if_req = 1'b1; if_addr = 32'h104; #1;
    checks++; if (if_gnt3 !== 1'b1) begin errors++; $display("FAIL wrap_gnt: got %b exp 1", if_gnt3); end
    for (int c = 1; c <= 6; c++) begin
      step(); if (c == 1) if_req = 1'b0; #1;
      checks++; if (mem_en3 !== (c == 1)) begin errors++; $display("FAIL wrap_mem_en c%0d: got %b", c, mem_en3); end
      checks++; if (if_rvalid3 !== (c == 5)) begin errors++; $display("FAIL wrap_if_rvalid c%0d: got %b", c, if_rvalid3); end
      if (c == 1) begin
        checks++; if (mem_addr3 !== 6'd1) begin errors++; $display("FAIL wrap_mem_addr: got %0d exp 1", mem_addr3); end
      end
      if (c == 5) begin
        checks++; if (if_rdata3 !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_rdata: got %h exp cafef00d", if_rdata3); end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (8) step();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h14; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b exp 1", ls_gnt); end
    step(); ls_req = 1'b0;
    step(); rst = 1'b1; #1;
    checks++; if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got nonzero (mem_addr=%h ls_rdata=%h)", mem_addr, ls_rdata); end
    step(); step(); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if ({ls_rvalid, if_rvalid, mem_en} !== 3'b000) begin
        errors++; $display("FAIL rstmid_quiet c%0d: got rvalid/en=%b exp 000", c, {ls_rvalid, if_rvalid, mem_en}); end
    end
    ls_req = 1'b1; ls_addr = 32'h14; #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_gnt: got %b exp 1", ls_gnt); end
    step(); ls_req = 1'b0;
    step(); step(); #1;
    checks++; if (ls_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_rvalid: got %b exp 1", ls_rvalid); end
    checks++; if (ls_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_fresh_rdata: got %h exp deadbeef", ls_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_fetch();
    test_simultaneous();
    test_latency3_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
